// File: rtl/iob_cache_be_arbiter_pkg.sv
// iob_cache_be_arbiter_pkg: shared policy codes and FSM state type for the back-end arbiter
package iob_cache_be_arbiter_pkg;
    localparam int ARB_RR = 0;
    localparam int ARB_FIXED = 1;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/iob_cache_be_arbiter_rr_sel.sv
// iob_cache_be_arbiter_rr_sel: picks the first request at or after prio, wrapping; prio=0 gives fixed priority
module iob_cache_be_arbiter_rr_sel #(
    parameter int N_MASTERS = 2,
    parameter int NM_W = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [NM_W-1:0]      prio,
    output logic [NM_W-1:0]      winner,
    output logic                 any
);
    logic [NM_W-1:0] lo, hi;
    logic hit;
    // lo: lowest request overall (the wrapped pick); hi: lowest request at or above prio
    always_comb begin
        lo = '0;
        hi = '0;
        hit = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            lo = req[i] ? NM_W'(i) : lo;
            if (req[i] && i >= int'(prio)) begin
                hi = NM_W'(i);
                hit = 1'b1;
            end
        end
        winner = hit ? hi : lo;
        any = |req;
    end
endmodule

// File: rtl/iob_cache_be_arbiter.sv
// iob_cache_be_arbiter: shares one native back-end memory port between N_MASTERS cache back-ends,
// one transaction at a time, with round-robin or fixed-priority arbitration.
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ARB_POLICY = ARB_RR,
    parameter int NM_W = $clog2(N_MASTERS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            mem_valid,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W/8-1:0]             mem_wstrb,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_ready
);
    state_t state;
    logic [NM_W-1:0] grant, prio, sel_prio, winner;
    logic any, busy;
    logic [ADDR_W-1:0] addr_a [N_MASTERS];
    logic [DATA_W-1:0] wdata_a [N_MASTERS];
    logic [DATA_W/8-1:0] wstrb_a [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
        assign addr_a[i] = m_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = m_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i] = m_wstrb[i*DATA_W/8 +: DATA_W/8];
    end

    assign sel_prio = (ARB_POLICY == ARB_FIXED) ? '0 : prio;

    iob_cache_be_arbiter_rr_sel #(.N_MASTERS(N_MASTERS), .NM_W(NM_W)) u_sel (
        .req(m_valid),
        .prio(sel_prio),
        .winner(winner),
        .any(any)
    );

    assign busy = state == BUSY;
    assign mem_valid = busy && m_valid[grant];
    assign mem_addr = busy ? addr_a[grant] : '0;
    assign mem_wdata = busy ? wdata_a[grant] : '0;
    assign mem_wstrb = busy ? wstrb_a[grant] : '0;
    assign m_ready = busy ? N_MASTERS'(mem_ready) << grant : '0;
    assign m_rdata = {N_MASTERS{mem_rdata}};

    // wrap compares against N_MASTERS-1 so non-power-of-2 counts stay in range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            prio <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                grant <= winner;
                state <= BUSY;
            end
        end else if (mem_ready) begin
            state <= IDLE;
            if (ARB_POLICY == ARB_RR) prio <= (grant == NM_W'(N_MASTERS - 1)) ? '0 : grant + NM_W'(1);
        end else if (!m_valid[grant]) begin
            state <= IDLE;
        end
    end
endmodule
